// File: rtl/axi4_wr_slave_ram.sv
// axi4_wr_slave_ram
// AXI4 write-channel responder that terminates a DMA write path. It accepts one
// AW/W burst at a time, commits beats into a byte-enabled RAM window at
// BASE_ADDR, and returns one B response per burst. It also provides a
// registered debug read port and traffic counters for payload checking.
module axi4_wr_slave_ram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic                          i_wstall,
  input  logic [$clog2(MEM_DEPTH)-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0]         dbg_rdata,
  output logic [31:0]                   o_burst_cnt,
  output logic [31:0]                   o_beat_cnt,
  output logic                          o_proto_err
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(MEM_DEPTH);

  // Depth widened to ADDR_WIDTH+1 bits so the end-of-burst range test cannot wrap.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT   = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [2:0]          SIZE_FULL   = 3'(SIZE_LOG2);
  localparam logic [1:0]          BURST_INCR  = 2'b01;
  localparam logic [1:0]          RESP_OKAY   = 2'b00;
  localparam logic [1:0]          RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             awready_q, awready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       beat_q, beat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             mism_q, mism_d;
  logic [31:0]      burst_cnt_q, burst_cnt_d;
  logic [31:0]      beat_cnt_q, beat_cnt_d;
  logic             proto_err_q, proto_err_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic              aw_hs, w_hs, b_hs, last_beat, mism_now, mem_we;
  logic [ADDR_WIDTH:0] aw_off, aw_word, aw_end;
  logic              aw_err;
  logic [STRB_W-1:0] lane_we;

  // W is only ever accepted while a burst is open; i_wstall injects backpressure.
  assign s_axi_wready = (state_q == DATA) && !i_wstall;

  assign aw_hs     = awready_q && s_axi_awvalid;
  assign w_hs      = s_axi_wready && s_axi_wvalid;
  assign b_hs      = bvalid_q && s_axi_bready;
  assign last_beat = (beat_q == len_q);
  assign mem_we    = w_hs && !err_q;

  // Word offset of the burst start; low address bits drop out in the shift.
  assign aw_off  = {1'b0, s_axi_awaddr} - {1'b0, BASE_ADDR};
  assign aw_word = aw_off >> SIZE_LOG2;
  assign aw_end  = aw_word + {{(ADDR_WIDTH-7){1'b0}}, s_axi_awlen};
  assign aw_err  = (s_axi_awburst != BURST_INCR) ||
                   (s_axi_awsize != SIZE_FULL) ||
                   (s_axi_awaddr < BASE_ADDR) ||
                   (aw_end >= DEPTH_EXT);

  // Per-lane write enables from the strobes.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane_we
      assign lane_we[gi] = mem_we && s_axi_wstrb[gi];
    end
  endgenerate

  // Next-state and output logic for the IDLE/DATA/RESP burst FSM.
  always_comb begin
    state_d     = state_q;
    awready_d   = awready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    len_d       = len_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    err_d       = err_q;
    mism_d      = mism_q;
    burst_cnt_d = burst_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    proto_err_d = proto_err_q;
    mism_now    = 1'b0;

    case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          awready_d = 1'b0;
          len_d     = s_axi_awlen;
          beat_d    = 8'd0;
          idx_d     = aw_word[IDX_W-1:0];
          err_d     = aw_err;
          mism_d    = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        awready_d = 1'b0;
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 32'd1;
          beat_d     = beat_q + 8'd1;
          idx_d      = idx_q + 1'b1;
          // WLAST must coincide exactly with the counted final beat.
          if (s_axi_wlast != last_beat) begin
            mism_now    = 1'b1;
            proto_err_d = 1'b1;
          end
          mism_d = mism_q | mism_now;
          if (last_beat) begin
            state_d  = RESP;
            bvalid_d = 1'b1;
            bresp_d  = (err_q || mism_q || mism_now) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      RESP: begin
        awready_d = 1'b0;
        if (b_hs) begin
          bvalid_d    = 1'b0;
          bresp_d     = RESP_OKAY;
          burst_cnt_d = burst_cnt_q + 32'd1;
          awready_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        awready_d = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and control registers; reset abandons any open burst without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      len_q       <= 8'd0;
      beat_q      <= 8'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      mism_q      <= 1'b0;
      burst_cnt_q <= 32'd0;
      beat_cnt_q  <= 32'd0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      mism_q      <= mism_d;
      burst_cnt_q <= burst_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Byte-enabled RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (lane_we[i]) mem[idx_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
    end
  end

  // Registered debug read; a same-cycle write to the word returns the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg_rdata_q <= '0;
    else        dbg_rdata_q <= mem[dbg_addr];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign dbg_rdata     = dbg_rdata_q;
  assign o_burst_cnt   = burst_cnt_q;
  assign o_beat_cnt    = beat_cnt_q;
  assign o_proto_err   = proto_err_q;

endmodule

// File: tb/tb_axi4_wr_slave_ram.sv
// Testbench for axi4_wr_slave_ram: directed burst sequence with randomized
// data, W stalls and B backpressure, checked against a word-array reference
// model and expected counter values derived from the burst rules.
module tb_axi4_wr_slave_ram;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        i_wstall;
  logic [9:0]  dbg_addr;
  logic [31:0] dbg_rdata, burst_cnt, beat_cnt;
  logic        proto_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state.
  logic [31:0] ref_mem [DEPTH];
  int          exp_beats  = 0;
  int          exp_bursts = 0;
  logic        exp_proto  = 1'b0;

  // Per-burst beat payload.
  logic [31:0] bd [256];
  logic [3:0]  bs [256];

  axi4_wr_slave_ram dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .i_wstall(i_wstall), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata),
    .o_burst_cnt(burst_cnt), .o_beat_cnt(beat_cnt), .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic dbg_chk(input int w);
    dbg_addr = 10'(w);
    @(posedge clk); #1;
    chk($sformatf("dbg[%0d]", w), dbg_rdata, ref_mem[w]);
  endtask

  // One burst: AW, beats from bd/bs, then B. abort_after >= 0 stops after that
  // beat and leaves the burst open (for reset testing).
  task automatic run_burst(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int bad_beat, input int abort_after,
                           input bit stall_en, input bit rand_br, input bit time_it);
    longint     off;
    bit         err, mism, got, seen;
    int         word0, nbeats, aw_c, b_c, t;
    logic [1:0] resp;
    off    = longint'(addr) - longint'(BASE);
    err    = (burst != 2'b01) || (size != 3'd2) || (off < 0) || ((off / 4) + len >= DEPTH);
    mism   = (bad_beat >= 0) && (bad_beat != len);
    word0  = int'(off / 4);
    nbeats = (abort_after >= 0) ? abort_after + 1 : len + 1;
    b_c    = 0;
    resp   = 2'b00;

    awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin @(posedge clk); #1; t++; end
    if (!awready) chk("aw_ready", 32'(awready), 32'd1);
    aw_c = cyc;
    @(posedge clk); #1;
    awvalid = 1'b0;

    for (int i = 0; i < nbeats; i++) begin
      wdata  = bd[i];
      wstrb  = bs[i];
      wlast  = (bad_beat >= 0) ? (i == bad_beat) : (i == len);
      wvalid = 1'b1;
      got    = 1'b0;
      for (t = 0; t < 200 && !got; t++) begin
        i_wstall = stall_en && ($urandom_range(0, 99) < 40);
        #1;
        got = wready;
        @(posedge clk); #1;
      end
      if (!got) chk("w_ready", 32'(wready), 32'd1);
      if (got && !err) begin
        for (int b = 0; b < 4; b++)
          if (bs[i][b]) ref_mem[word0 + i][b*8 +: 8] = bd[i][b*8 +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0; i_wstall = 1'b0;
    exp_beats += nbeats;
    if (abort_after >= 0) return;
    if (mism) exp_proto = 1'b1;

    seen = 1'b0; got = 1'b0;
    for (t = 0; t < 300 && !got; t++) begin
      bready = rand_br ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bvalid && !seen) begin seen = 1'b1; b_c = cyc; end
      if (bvalid && bready) begin got = 1'b1; resp = bresp; end
      @(posedge clk); #1;
    end
    bready = 1'b0;
    if (!got) chk("b_valid", 32'(bvalid), 32'd1);
    else exp_bursts++;

    chk("bresp", 32'(resp), (err || mism) ? 32'd2 : 32'd0);
    chk("bvalid_drop", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
    chk("beat_cnt", beat_cnt, 32'(exp_beats));
    chk("burst_cnt", burst_cnt, 32'(exp_bursts));
    chk("proto_err", 32'(proto_err), 32'(exp_proto));
    if (time_it) chk("latency", 32'(b_c - aw_c), 32'(len + 2));
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i <= len; i++) begin bd[i] = $urandom; bs[i] = 4'hF; end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_awready"},   32'(awready), 32'd0);
    chk({tag, "_wready"},    32'(wready), 32'd0);
    chk({tag, "_bvalid"},    32'(bvalid), 32'd0);
    chk({tag, "_bresp"},     32'(bresp), 32'd0);
    chk({tag, "_burst_cnt"}, burst_cnt, 32'd0);
    chk({tag, "_beat_cnt"},  beat_cnt, 32'd0);
    chk({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 32'd0);
  endtask

  initial begin
    int w, len;
    rst_n = 1'b1;
    awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; i_wstall = 1'b0; dbg_addr = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    // Reset values.
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("awready_after_reset", 32'(awready), 32'd1);

    // W before AW must stall.
    wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("wready_idle", 32'(wready), 32'd0);
    wvalid = 1'b0;

    // 16-beat INCR, data = index, no stalls, latency measured.
    for (int i = 0; i < 16; i++) begin bd[i] = 32'(i); bs[i] = 4'hF; end
    run_burst(BASE, 15, 2'b01, 3'd2, -1, -1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) dbg_chk(i);

    // DMA-like 2048-byte payload with random burst lengths, W stalls, B backpressure.
    w = 0;
    while (w < 512) begin
      len = $urandom_range(0, 15);
      if (w + len > 511) len = 511 - w;
      fill_rand(len);
      run_burst(BASE + 32'(w * 4), len, 2'b01, 3'd2, -1, -1, 1'b1, 1'b1, 1'b0);
      w += len + 1;
    end
    for (int i = 0; i < 512; i++) dbg_chk(i);

    // Partial-strobe merge onto a preloaded word.
    bd[0] = 32'hAABB_CCDD; bs[0] = 4'hF;
    run_burst(BASE + 32'd12, 0, 2'b01, 3'd2, -1, -1, 1'b0, 1'b0, 1'b0);
    bd[0] = 32'h1122_3344; bs[0] = 4'b0101;
    run_burst(BASE + 32'd12, 0, 2'b01, 3'd2, -1, -1, 1'b0, 1'b0, 1'b0);
    dbg_chk(3);
    chk("strobe_merge", dbg_rdata, 32'hAA22_CC44);

    // Out-of-range burst: the top four words must survive.
    fill_rand(3);
    run_burst(BASE + 32'hFF0, 3, 2'b01, 3'd2, -1, -1, 1'b0, 1'b1, 1'b0);
    fill_rand(7);
    run_burst(BASE + 32'hFF0, 7, 2'b01, 3'd2, -1, -1, 1'b1, 1'b0, 1'b0);
    for (int i = 1020; i < 1024; i++) dbg_chk(i);

    // Outside the window, FIXED burst, wrong beat size.
    fill_rand(0);
    run_burst(32'h2000_0000, 0, 2'b01, 3'd2, -1, -1, 1'b0, 1'b0, 1'b0);
    fill_rand(3);
    run_burst(BASE, 3, 2'b00, 3'd2, -1, -1, 1'b0, 1'b0, 1'b0);
    fill_rand(1);
    run_burst(BASE + 32'd16, 1, 2'b01, 3'd1, -1, -1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) dbg_chk(i);

    // Early WLAST, then a clean burst: proto_err stays set.
    fill_rand(3);
    run_burst(BASE + 32'h100, 3, 2'b01, 3'd2, 1, -1, 1'b0, 1'b0, 1'b0);
    fill_rand(2);
    run_burst(BASE + 32'h140, 2, 2'b01, 3'd2, -1, -1, 1'b1, 1'b1, 1'b0);
    for (int i = 64; i < 67; i++) dbg_chk(i);
    for (int i = 80; i < 83; i++) dbg_chk(i);

    // Reset after beat 2 of an 8-beat burst.
    fill_rand(7);
    run_burst(BASE + 32'h200, 7, 2'b01, 3'd2, -1, 2, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_bvalid", 32'(bvalid), 32'd0);
    exp_beats = 0; exp_bursts = 0; exp_proto = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_awready", 32'(awready), 32'd1);
    fill_rand(5);
    run_burst(BASE + 32'h300, 5, 2'b01, 3'd2, -1, -1, 1'b1, 1'b1, 1'b0);
    for (int i = 128; i < 131; i++) dbg_chk(i);
    for (int i = 192; i < 198; i++) dbg_chk(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
